// File: rtl/mem_channel_arbiter.sv
// mem_channel_arbiter: shares NUM_CHANNELS memory channels among NUM_CONSUMERS
// LSUs. Each channel serves one request at a time through its own handshake
// FSM; idle channels pick new owners round-robin from a shared pointer.
module mem_channel_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 2
) (
  input  logic                                     clk,
  input  logic                                     reset,

  input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,

  output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
  output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                  mem_write_ready,
  output logic [NUM_CHANNELS-1:0]                  channel_busy
);

  localparam int          CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int unsigned NC = NUM_CONSUMERS;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    RESPOND,
    DRAIN
  } state_t;

  state_t                                  state_q [NUM_CHANNELS];
  state_t                                  state_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0][CW-1:0]         owner_q, owner_d;
  logic [NUM_CHANNELS-1:0]                 served_read_q, served_read_d;
  logic [CW-1:0]                           rr_ptr_q, rr_ptr_d;

  logic [NUM_CHANNELS-1:0]                 mem_read_valid_q, mem_read_valid_d;
  logic [NUM_CHANNELS-1:0]                 mem_write_valid_q, mem_write_valid_d;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address_q, mem_read_address_d;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address_q, mem_write_address_d;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data_q, mem_write_data_d;
  logic [NUM_CHANNELS-1:0]                 channel_busy_q, channel_busy_d;
  logic [NUM_CONSUMERS-1:0]                consumer_read_ready_q, consumer_read_ready_d;
  logic [NUM_CONSUMERS-1:0]                consumer_write_ready_q, consumer_write_ready_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data_q, consumer_read_data_d;

  // Arbitration scratch
  logic [NUM_CONSUMERS-1:0]                owned;
  logic [NUM_CONSUMERS-1:0]                taken;
  logic                                    found;
  logic                                    granted;
  logic [CW-1:0]                           last_grant;
  logic [CW-1:0]                           cand;
  int unsigned                             sum;

  // Next-state: per-channel handshake plus one round-robin grant pass over idle channels
  always_comb begin
    state_d                = state_q;
    owner_d                = owner_q;
    served_read_d          = served_read_q;
    rr_ptr_d               = rr_ptr_q;
    mem_read_valid_d       = mem_read_valid_q;
    mem_write_valid_d      = mem_write_valid_q;
    mem_read_address_d     = mem_read_address_q;
    mem_write_address_d    = mem_write_address_q;
    mem_write_data_d       = mem_write_data_q;
    consumer_read_data_d   = consumer_read_data_q;
    consumer_read_ready_d  = '0;
    consumer_write_ready_d = '0;
    channel_busy_d         = '0;
    owned                  = '0;
    taken                  = '0;
    found                  = 1'b0;
    granted                = 1'b0;
    last_grant             = '0;
    cand                   = '0;
    sum                    = '0;

    // A consumer held by any non-idle channel (WAIT, RESPOND or DRAIN) is not eligible
    for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (state_q[ch] != IDLE) owned[owner_q[ch]] = 1'b1;
    end

    for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
      case (state_q[ch])
        IDLE: begin
          found = 1'b0;
          for (int unsigned k = 0; k < NC; k++) begin
            sum = 32'(rr_ptr_q) + k;
            if (sum >= NC) sum = sum - NC;
            cand = CW'(sum);
            if (!found && (consumer_read_valid[cand] || consumer_write_valid[cand]) &&
                !owned[cand] && !taken[cand]) begin
              found       = 1'b1;
              taken[cand] = 1'b1;
              granted     = 1'b1;
              last_grant  = cand;
              owner_d[ch] = cand;
              if (consumer_read_valid[cand]) begin
                state_d[ch]            = READ_WAIT;
                served_read_d[ch]      = 1'b1;
                mem_read_valid_d[ch]   = 1'b1;
                mem_read_address_d[ch] = consumer_read_address[cand];
              end else begin
                state_d[ch]             = WRITE_WAIT;
                served_read_d[ch]       = 1'b0;
                mem_write_valid_d[ch]   = 1'b1;
                mem_write_address_d[ch] = consumer_write_address[cand];
                mem_write_data_d[ch]    = consumer_write_data[cand];
              end
            end
          end
        end
        READ_WAIT: begin
          if (mem_read_ready[ch]) begin
            consumer_read_data_d[owner_q[ch]]  = mem_read_data[ch];
            consumer_read_ready_d[owner_q[ch]] = 1'b1;
            mem_read_valid_d[ch]               = 1'b0;
            state_d[ch]                        = RESPOND;
          end
        end
        WRITE_WAIT: begin
          if (mem_write_ready[ch]) begin
            consumer_write_ready_d[owner_q[ch]] = 1'b1;
            mem_write_valid_d[ch]               = 1'b0;
            state_d[ch]                         = RESPOND;
          end
        end
        RESPOND: state_d[ch] = DRAIN;
        DRAIN: begin
          if (served_read_q[ch] ? !consumer_read_valid[owner_q[ch]]
                                : !consumer_write_valid[owner_q[ch]])
            state_d[ch] = IDLE;
        end
        default: state_d[ch] = IDLE;
      endcase
      channel_busy_d[ch] = (state_d[ch] != IDLE);
    end

    if (granted) rr_ptr_d = (last_grant == CW'(NC - 1)) ? '0 : last_grant + 1'b1;
  end

  // State and registered outputs; the consumer ready pulse is registered on
  // entry to RESPOND so it is high exactly for the RESPOND cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) state_q[ch] <= IDLE;
      owner_q                <= '0;
      served_read_q          <= '0;
      rr_ptr_q               <= '0;
      mem_read_valid_q       <= '0;
      mem_write_valid_q      <= '0;
      mem_read_address_q     <= '0;
      mem_write_address_q    <= '0;
      mem_write_data_q       <= '0;
      channel_busy_q         <= '0;
      consumer_read_ready_q  <= '0;
      consumer_write_ready_q <= '0;
      consumer_read_data_q   <= '0;
    end else begin
      for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) state_q[ch] <= state_d[ch];
      owner_q                <= owner_d;
      served_read_q          <= served_read_d;
      rr_ptr_q               <= rr_ptr_d;
      mem_read_valid_q       <= mem_read_valid_d;
      mem_write_valid_q      <= mem_write_valid_d;
      mem_read_address_q     <= mem_read_address_d;
      mem_write_address_q    <= mem_write_address_d;
      mem_write_data_q       <= mem_write_data_d;
      channel_busy_q         <= channel_busy_d;
      consumer_read_ready_q  <= consumer_read_ready_d;
      consumer_write_ready_q <= consumer_write_ready_d;
      consumer_read_data_q   <= consumer_read_data_d;
    end
  end

  assign mem_read_valid       = mem_read_valid_q;
  assign mem_write_valid      = mem_write_valid_q;
  assign mem_read_address     = mem_read_address_q;
  assign mem_write_address    = mem_write_address_q;
  assign mem_write_data       = mem_write_data_q;
  assign channel_busy         = channel_busy_q;
  assign consumer_read_ready  = consumer_read_ready_q;
  assign consumer_write_ready = consumer_write_ready_q;
  assign consumer_read_data   = consumer_read_data_q;

endmodule
